// File: rtl/scfifo_s_stream_out.sv
// Read-side adapter: drains scfifo_s_normal into a valid/ready stream via a prefetch buffer.
// Define SCFIFO_S_STREAM_OUT_CHECK_EN to add the sticky err flag and the out_level port.
module scfifo_s_stream_out #(
   parameter int  WIDTH        = 20,
   parameter int  READ_LATENCY = 1,
   parameter int  BUF_DEPTH    = READ_LATENCY + 2,
   localparam int CW           = $clog2(BUF_DEPTH + 1),
   localparam int PW           = $clog2(BUF_DEPTH)
) (
   input  logic             clock,
   input  logic             aclr,
   input  logic             sclr,
   input  logic [WIDTH-1:0] fifo_q,
   input  logic             fifo_empty,
   output logic             fifo_rdreq,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
`ifdef SCFIFO_S_STREAM_OUT_CHECK_EN
   output logic             err,
   output logic [CW-1:0]    out_level,
`endif
   output logic             out_valid
);

   if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
      $error("scfifo_s_stream_out: READ_LATENCY must be 1..3");
   end
   if (BUF_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
      $error("scfifo_s_stream_out: BUF_DEPTH must be >= READ_LATENCY+2");
   end

   logic [BUF_DEPTH-1:0][WIDTH-1:0] mem;
   logic [CW-1:0]                   count;
   logic [PW-1:0]                   wr_ptr;
   logic [PW-1:0]                   rd_ptr;
   logic [READ_LATENCY-1:0]         trk;
   logic [READ_LATENCY:0]           trk_sh;
   logic [CW:0]                     occ;
   logic                            push;
   logic                            pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push     = trk[READ_LATENCY-1];
   assign pop      = out_valid && out_ready;
   assign trk_sh   = {trk, fifo_rdreq};
   assign occ      = {1'b0, count} + (CW+1)'($countones(trk));

   // Only registered terms here: out_ready never reaches fifo_rdreq.
   assign fifo_rdreq = !aclr && !sclr && !fifo_empty
                       && (occ < (CW+1)'(BUF_DEPTH));

   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         trk    <= '0;
         mem    <= '0;
      end else if (sclr) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         trk    <= '0;
         mem    <= '0;
      end else begin
         trk   <= trk_sh[READ_LATENCY-1:0];
         count <= count + CW'(push) - CW'(pop);
         if (push) begin
            mem[wr_ptr] <= fifo_q;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= nxt(rd_ptr);
         end
      end
   end

`ifdef SCFIFO_S_STREAM_OUT_CHECK_EN
   assign out_level = count;

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         err <= 1'b0;
      end else if (sclr) begin
         err <= 1'b0;
      end else if ((push && count == CW'(BUF_DEPTH)) ||
                   (pop && count == '0)) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_scfifo_s_stream_out.sv
// Bench for scfifo_s_stream_out: upstream FIFO model, scoreboard monitor, directed and random phases.
// Builds with or without SCFIFO_S_STREAM_OUT_CHECK_EN.
module tb_scfifo_s_stream_out;

   localparam int W  = 20;
   localparam int RL = 1;
   localparam int BD = 3;

   logic         clock = 1'b0;
   logic         aclr = 1'b1;
   logic         sclr = 1'b0;
   logic [W-1:0] fifo_q = '0;
   logic         fifo_empty = 1'b1;
   logic         fifo_rdreq;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
`ifdef SCFIFO_S_STREAM_OUT_CHECK_EN
   logic         err;
   logic [1:0]   out_level;
`endif

   int           checks = 0;
   int           fails = 0;
   logic [W-1:0] src[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] nextw = 1;
   bit           stall = 0;
   logic [W-1:0] stall_data = '0;

   always #5 clock = ~clock;

   scfifo_s_stream_out #(
      .WIDTH(W), .READ_LATENCY(RL), .BUF_DEPTH(BD)
   ) dut (
      .clock(clock),
      .aclr(aclr),
      .sclr(sclr),
      .fifo_q(fifo_q),
      .fifo_empty(fifo_empty),
      .fifo_rdreq(fifo_rdreq),
      .out_data(out_data),
      .out_ready(out_ready),
`ifdef SCFIFO_S_STREAM_OUT_CHECK_EN
      .err(err),
      .out_level(out_level),
`endif
      .out_valid(out_valid)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic put_word(input logic [W-1:0] w);
      src.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic put(input int n);
      repeat (n) begin
         put_word(nextw);
         nextw = nextw + 1'b1;
      end
   endtask

   task automatic drain(input string name, input int budget);
      int t = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || src.size() != 0) && t < budget) begin
         step();
         t++;
      end
      repeat (3) step();
      chk({name, "_drained"}, 32'(exp_q.size()), 0);
   endtask

   // Upstream FIFO: registered q one cycle after rdreq, registered empty.
   always @(posedge clock) begin
      if (fifo_rdreq && src.size() != 0) fifo_q <= src.pop_front();
      fifo_empty <= (src.size() == 0);
   end

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clock) begin
      if (stall && !sclr && !aclr) begin
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_data", 32'(out_data), 32'(stall_data));
      end
      stall = out_valid && !out_ready && !sclr && !aclr;
      stall_data = out_data;
      if (fifo_rdreq) chk("rdreq_when_empty", 32'(fifo_empty), 0);
      if (out_valid && out_ready && !aclr && !sclr) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL sb_underrun: got %0h, required none", out_data);
         end else begin
            chk("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nrd;
      int pushed;
      int t;

      #2;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_rdreq", 32'(fifo_rdreq), 0);
      chk("rst_data", 32'(out_data), 0);
      step();
      step();
      aclr = 1'b0;
      step();

      // First-word latency and gap-free streaming
      out_ready = 1'b1;
      put(5);
      @(posedge clock);
      @(negedge clock);
      chk("c0_rdreq", 32'(fifo_rdreq), 1);
      @(negedge clock);
      chk("c1_valid", 32'(out_valid), 0);
      @(negedge clock);
      chk("c2_valid", 32'(out_valid), 1);
      chk("c2_data", 32'(out_data), 1);
      for (int k = 3; k <= 6; k++) begin
         @(negedge clock);
         chk("stream_valid", 32'(out_valid), 1);
         chk("stream_data", 32'(out_data), 32'(k - 1));
      end
      step();
      drain("first", 200);

      // Asynchronous clear with a full buffer and a pending word upstream
      out_ready = 1'b0;
      put(4);
      repeat (8) step();
      chk("pre_aclr_valid", 32'(out_valid), 1);
      @(posedge clock);
      #3;
      aclr = 1'b1;
      #1;
      chk("aclr_valid", 32'(out_valid), 0);
      chk("aclr_rdreq", 32'(fifo_rdreq), 0);
      chk("aclr_data", 32'(out_data), 0);
      exp_q = src;
      @(posedge clock);
      #1;
      aclr = 1'b0;
      drain("aclr", 200);

      // Back-pressure: only BD reads issue, head word held
      step();
      out_ready = 1'b0;
      nextw = 1;
      put(10);
      nrd = 0;
      repeat (20) begin
         @(negedge clock);
         if (fifo_rdreq) nrd++;
         if (out_valid) chk("bp_data", 32'(out_data), 1);
      end
      chk("bp_rdreq_count", 32'(nrd), 3);
      chk("bp_valid", 32'(out_valid), 1);
      step();
      drain("bp", 200);

      // Synchronous clear with one word buffered and one in flight
      step();
      out_ready = 1'b0;
      put(6);
      step();
      step();
      step();
      chk("pre_sclr_valid", 32'(out_valid), 1);
      sclr = 1'b1;
      #1;
      chk("sclr_rdreq_comb", 32'(fifo_rdreq), 0);
      step();
      sclr = 1'b0;
      chk("sclr_valid", 32'(out_valid), 0);
      chk("sclr_count", 32'(dut.count), 0);
      exp_q = src;
      drain("sclr", 200);

      // Random ready and random arrival
      pushed = 0;
      t = 0;
      while ((pushed < 1000 || exp_q.size() != 0) && t < 20000) begin
         step();
         t++;
         out_ready = 1'($urandom % 2);
         if (pushed < 1000 && ($urandom % 2) == 1) begin
            put_word(W'($urandom));
            pushed++;
         end
      end
      chk("rand_done", 32'(exp_q.size()), 0);
`ifdef SCFIFO_S_STREAM_OUT_CHECK_EN
      chk("rand_err", 32'(err), 0);

      // Push into a full buffer via override
      step();
      out_ready = 1'b0;
      put(3);
      repeat (6) step();
      chk("level_full", 32'(out_level), 3);
      force dut.trk = 1'b1;
      step();
      release dut.trk;
      step();
      chk("err_set", 32'(err), 1);
      repeat (3) step();
      chk("err_sticky", 32'(err), 1);
      sclr = 1'b1;
      step();
      sclr = 1'b0;
      chk("err_clr", 32'(err), 0);
      exp_q.delete();
`endif
      step();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/scfifo_s_stream_out.md
Name: scfifo_s_stream_out

Overview:
- Read-side adapter placed directly downstream of the normal-mode single-clock FIFO (scfifo_s_normal).
- Drives the FIFO's rdreq, captures fifo_q after a fixed read latency, and presents it as a valid/ready stream.
- A small prefetch buffer gives full throughput and keeps out_ready off the fifo_rdreq timing path.

Parameters:
- WIDTH, 20, data width; must match the upstream FIFO.
- READ_LATENCY, 1, cycles from fifo_rdreq asserted to the word being present on fifo_q. Legal range 1..3; $error outside it.
- BUF_DEPTH, READ_LATENCY+2, prefetch buffer entries. Must be >= READ_LATENCY+2; $error otherwise.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- aclr  in  1  asynchronous, active-high reset.
- sclr  in  1  synchronous clear, active-high.
- fifo_q  in  WIDTH  upstream FIFO read data.
- fifo_empty  in  1  upstream FIFO empty flag, registered in the FIFO.
- fifo_rdreq  out  1  read request to the upstream FIFO.
- out_data  out  WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the consumer.

Behaviour:
- Clocking/reset: one clock, clock. aclr is asynchronous, active-high, and takes priority over sclr. sclr is synchronous.
- aclr or sclr clears: buffer count, read/write pointers, in-flight tracker and all buffer entries (to 0).
- Output values under reset: out_valid=0, out_data=0, fifo_rdreq=0.
- sclr additionally forces fifo_rdreq=0 combinationally in the same cycle.
- In-flight tracker: READ_LATENCY-bit shift register.
  - Bit 0 <= fifo_rdreq each cycle.
  - The top bit set means fifo_q carries a valid word this cycle; that word is written at buffer[wr_ptr] on the closing edge.
- infl = popcount of the tracker.
- Issue rule, purely registered inputs: fifo_rdreq = !fifo_empty && !sclr && (count + infl < BUF_DEPTH).
  - No combinational path from out_ready to fifo_rdreq.
- Buffer: circular, BUF_DEPTH entries, pointers wrap modulo BUF_DEPTH.
- count update: count_next = count + push - pop.
  - push = top tracker bit; pop = out_valid && out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Width is $clog2(BUF_DEPTH+1).
- Outputs: out_valid = (count != 0); out_data = buffer[rd_ptr], a registered-source mux.
- Stream rule: while out_valid=1 and out_ready=0, out_data is held stable.
- Latency: fifo_rdreq in cycle t -> word on fifo_q in cycle t+READ_LATENCY -> out_valid=1 in cycle t+READ_LATENCY+1.
  - First-word latency from fifo_empty falling is READ_LATENCY+1 cycles.
- Throughput: with out_ready held 1 and the FIFO never empty, one word per cycle in steady state.
- Empty boundary: no underflow protection is needed. The FIFO's empty flag already accounts for the read issued in the previous cycle, so fifo_rdreq never asserts against an empty FIFO.
- Full boundary: count + infl == BUF_DEPTH blocks issue. A push therefore never finds count == BUF_DEPTH.
- Back-pressure: out_ready=0 indefinitely -> buffer fills to BUF_DEPTH, fifo_rdreq stays 0, no data lost.
- sclr mid-operation: in-flight words arriving after sclr are discarded because the tracker is cleared. out_valid=0 the cycle after sclr.
- aclr mid-operation: all state cleared immediately, outputs as under reset.
- Ordering: words are delivered in FIFO order, none duplicated.

Optional Feature:
- Macro: SCFIFO_S_STREAM_OUT_CHECK_EN.
- Defined:
  - Adds output err (1 bit, sticky, cleared only by aclr/sclr).
  - err sets on push while count == BUF_DEPTH, or on pop while count == 0.
  - Adds an out_level port (width of count) reflecting count.
- Undefined: neither port nor the checking logic exists. Functional behaviour is otherwise identical.

Test Plan (READ_LATENCY=1, BUF_DEPTH=3, WIDTH=20):
- Reset: aclr pulse mid-cycle -> out_valid=0, fifo_rdreq=0, out_data=0 immediately.
- First-word latency: FIFO preloaded with 0x00001..0x00005, out_ready=1, fifo_empty falls at cycle 0.
  - fifo_rdreq=1 in cycle 0.
  - out_valid=1 with 0x00001 in cycle 2.
  - Values 0x00002..0x00005 follow on consecutive cycles, with no bubbles.
- Back-pressure: 10 words queued, out_ready=0.
  - fifo_rdreq asserts exactly 3 times, then holds 0.
  - out_data stays 0x00001.
  - Releasing out_ready delivers all 10 in order.
- Random ready: out_ready 50% random over 1000 words -> sequence matches the scoreboard exactly, and no rdreq while fifo_empty=1.
- sclr with 2 words in flight/buffered:
  - out_valid=0 next cycle; count=0.
  - The word arriving the cycle after sclr is dropped.
  - The next word read is the first post-sclr word.
- With SCFIFO_S_STREAM_OUT_CHECK_EN: force a push into a full buffer via bench override -> err=1 and stays 1 until sclr. In the normal random test, err stays 0.
